rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single write port of the 2R1W 32b 8-entry register file between two
//  writeback sources: req0 = ALU result, req1 = load/memory result.
//  Uses valid/ready handshakes, round-robin (or fixed) arbitration and a registered
//  write port driving the file's we/wa/wd. Sits between the execute/memory stages
//  and the register file.
// PARAMETERS
//  ADDR_W  3   register address width (8 entries)
//  DATA_W  32  write data width
//  RR      1   1 = round-robin between req0/req1; 0 = fixed priority, req0 always wins
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       synchronous reset, active-high
//  hold       in   1       1 = grant nothing this cycle (pipeline freeze)
//  v0         in   1       req0 valid
//  a0         in   ADDR_W  req0 destination register
//  d0         in   DATA_W  req0 write data
//  rdy0       out  1       req0 accepted this cycle (combinational)
//  v1         in   1       req1 valid
//  a1         in   ADDR_W  req1 destination register
//  d1         in   DATA_W  req1 write data
//  rdy1       out  1       req1 accepted this cycle (combinational)
//  we         out  1       to register file write enable (registered)
//  wa         out  ADDR_W  to register file write address (registered)
//  wd         out  DATA_W  to register file write data (registered)
//  conflicts  out  8       saturating count of cycles with v0 & v1 & !hold
// BEHAVIOUR
//  - Reset (rst=1 at posedge): we=0, wa=0, wd=0, conflicts=0, last_gnt=1 (req0 wins
//    first conflict). rdy0/rdy1 are 0 while rst=1. Reset mid-write: registered write
//    is dropped, we=0 next cycle.
//  - Grant (combinational, same cycle): hold=1 -> rdy0=rdy1=0. Only one valid -> that
//    source is granted. Both valid -> RR=1: source != last_gnt; RR=0: req0.
//    At most one rdy high per cycle. rdy never asserts without its valid.
//  - Transfer = v & rdy. On transfer, posedge loads we=1, wa=a, wd=d from the granted
//    source and last_gnt = granted index. No transfer -> we=0; wa/wd hold value.
//  - Latency: request accepted in cycle N -> we/wa/wd visible in N+1 -> file updated at
//    the end of N+1. Sustained throughput: one write per cycle.
//  - Requester keeps v/a/d stable until rdy; a source losing arbitration retries.
//    With RR=1 no source waits more than 1 cycle while hold=0.
//  - Same address from both sources in one cycle: only the granted one writes; the
//    loser writes the next cycle (its value ends up in the file). No merging.
//  - last_gnt updates only on an actual transfer, not on hold or idle cycles.
//  - conflicts increments when v0&v1&!hold and saturates at 255. hold has no effect
//    on it otherwise.
// CONFIGURATION
//  RF_WB_FWD_EN defined: adds ports ra1, ra2 (in ADDR_W), rf_rd1, rf_rd2 (in DATA_W,
//    raw file outputs) and fwd_rd1, fwd_rd2 (out DATA_W).
//    fwd_rdX = (we && wa==raX) ? wd : rf_rdX. Purely combinational; covers the cycle
//    before the file is updated.
//  RF_WB_FWD_EN undefined: these ports and the mux do not exist; readers take data
//    from the file directly, and consumers stall one cycle on a RAW hazard.
// TESTING
//  1 rst=1 two cycles with v0=v1=1 -> rdy0=rdy1=0, we=0, conflicts=0 throughout.
//  2 v0=1,a0=3,d0=0xDEADBEEF alone -> rdy0=1 same cycle; next cycle we=1,wa=3,
//    wd=0xDEADBEEF; following idle cycle we=0.
//  3 RR=1, v0,v1 held high 4 cycles (a0=1, a1=2) -> grants 0,1,0,1; we pattern
//    1,1,1,1 from cycle 2; conflicts=4.
//  4 RR=0, same stimulus -> req0 granted every cycle, rdy1=0 until v0 drops, then
//    req1 written one cycle after.
//  5 hold=1 with v0=v1=1 for 3 cycles -> no rdy, we=0, last_gnt unchanged,
//    conflicts unchanged; release -> correct RR order resumes.
//  6 FWD_EN: write r5=0x12345678 accepted, ra1=5 the next cycle -> fwd_rd1=0x12345678
//    while rf_rd1 is still old; ra2=4 -> fwd_rd2=rf_rd2.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source writeback arbiter driving the register file write port
// Optional read-after-write forwarding mux enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter bit RR     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              v0,
  input  logic [ADDR_W-1:0] a0,
  input  logic [DATA_W-1:0] d0,
  output logic              rdy0,
  input  logic              v1,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] d1,
  output logic              rdy1,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic [7:0]        conflicts
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] fwd_rd1,
  output logic [DATA_W-1:0] fwd_rd2
`endif
);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              last_gnt_q, last_gnt_d;
  logic [7:0]        conflicts_q, conflicts_d;
  logic              gnt0, gnt1;

  // With both valid under round-robin, the source that did not win last transfer goes.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !hold) begin
      if (v0 && v1) begin
        if (RR && !last_gnt_q) gnt1 = 1'b1;
        else                   gnt0 = 1'b1;
      end else if (v0) begin
        gnt0 = 1'b1;
      end else if (v1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    we_d        = gnt0 | gnt1;
    wa_d        = wa_q;
    wd_d        = wd_q;
    last_gnt_d  = last_gnt_q;
    conflicts_d = conflicts_q;
    if (gnt0) begin
      wa_d       = a0;
      wd_d       = d0;
      last_gnt_d = 1'b0;
    end else if (gnt1) begin
      wa_d       = a1;
      wd_d       = d1;
      last_gnt_d = 1'b1;
    end
    if (v0 && v1 && !hold && conflicts_q != 8'hFF) conflicts_d = conflicts_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      last_gnt_q  <= 1'b1;
      conflicts_q <= 8'd0;
    end else begin
      we_q        <= we_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      last_gnt_q  <= last_gnt_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign rdy0      = gnt0;
  assign rdy1      = gnt1;
  assign we        = we_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign conflicts = conflicts_q;

`ifdef RF_WB_FWD_EN
  // Bypass the pending write to readers during the cycle before the file holds it.
  assign fwd_rd1 = (we_q && wa_q == ra1) ? wd_q : rf_rd1;
  assign fwd_rd2 = (we_q && wa_q == ra2) ? wd_q : rf_rd2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed vector bench for rf_wb_arbiter (RR and fixed-priority instances)
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, hold, v0, v1;
  logic [2:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rdy0_r, rdy1_r, we_r, rdy0_f, rdy1_f, we_f;
  logic [2:0]  wa_r, wa_f;
  logic [31:0] wd_r, wd_f;
  logic [7:0]  cf_r, cf_f;
`ifdef RF_WB_FWD_EN
  logic [2:0]  ra1, ra2;
  logic [31:0] rf_rd1, rf_rd2, fwd1_r, fwd2_r, fwd1_f, fwd2_f;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.ADDR_W(3), .DATA_W(32), .RR(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .hold(hold),
    .v0(v0), .a0(a0), .d0(d0), .rdy0(rdy0_r),
    .v1(v1), .a1(a1), .d1(d1), .rdy1(rdy1_r),
    .we(we_r), .wa(wa_r), .wd(wd_r), .conflicts(cf_r)
`ifdef RF_WB_FWD_EN
    , .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_rd1(fwd1_r), .fwd_rd2(fwd2_r)
`endif
  );

  rf_wb_arbiter #(.ADDR_W(3), .DATA_W(32), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .hold(hold),
    .v0(v0), .a0(a0), .d0(d0), .rdy0(rdy0_f),
    .v1(v1), .a1(a1), .d1(d1), .rdy1(rdy1_f),
    .we(we_f), .wa(wa_f), .wd(wd_f), .conflicts(cf_f)
`ifdef RF_WB_FWD_EN
    , .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .fwd_rd1(fwd1_f), .fwd_rd2(fwd2_f)
`endif
  );

  typedef struct {
    logic        rst, hold, v0;
    logic [2:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [2:0]  a1;
    logic [31:0] d1;
    logic        e_rdy0, e_rdy1, e_we;
    logic [2:0]  e_wa;
    logic [31:0] e_wd;
    logic [7:0]  e_cf;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic r, logic h, logic iv0, logic [2:0] ia0, logic [31:0] id0,
                              logic iv1, logic [2:0] ia1, logic [31:0] id1,
                              logic er0, logic er1, logic ewe, logic [2:0] ewa,
                              logic [31:0] ewd, logic [7:0] ecf);
    vec_t t;
    t.rst = r; t.hold = h; t.v0 = iv0; t.a0 = ia0; t.d0 = id0;
    t.v1 = iv1; t.a1 = ia1; t.d1 = id1;
    t.e_rdy0 = er0; t.e_rdy1 = er1; t.e_we = ewe; t.e_wa = ewa; t.e_wd = ewd; t.e_cf = ecf;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic iv0, input logic [2:0] ia0,
                       input logic [31:0] id0, input logic iv1, input logic [2:0] ia1,
                       input logic [31:0] id1);
    rst = r; hold = h; v0 = iv0; a0 = ia0; d0 = id0; v1 = iv1; a1 = ia1; d1 = id1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
`ifdef RF_WB_FWD_EN
    ra1 = 3'd0; ra2 = 3'd0; rf_rd1 = 32'd0; rf_rd2 = 32'd0;
`endif
    //            rst hold v0 a0   d0            v1 a1   d1        rdy0 rdy1 we wa  wd            cf
    tbl[0]  = mk(1, 0, 1, 3'd1, 32'h1,        1, 3'd2, 32'h2,  0, 0, 0, 3'd0, 32'h0,        8'd0);
    tbl[1]  = mk(1, 0, 1, 3'd1, 32'h1,        1, 3'd2, 32'h2,  0, 0, 0, 3'd0, 32'h0,        8'd0);
    tbl[2]  = mk(0, 0, 1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 32'h0,  1, 0, 1, 3'd3, 32'hDEADBEEF, 8'd0);
    tbl[3]  = mk(0, 0, 0, 3'd0, 32'h0,        0, 3'd0, 32'h0,  0, 0, 0, 3'd3, 32'hDEADBEEF, 8'd0);
    tbl[4]  = mk(0, 0, 0, 3'd0, 32'h0,        1, 3'd7, 32'h77, 0, 1, 1, 3'd7, 32'h77,       8'd0);
    tbl[5]  = mk(0, 0, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 1, 0, 1, 3'd1, 32'h11,       8'd1);
    tbl[6]  = mk(0, 0, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 0, 1, 1, 3'd2, 32'h22,       8'd2);
    tbl[7]  = mk(0, 0, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 1, 0, 1, 3'd1, 32'h11,       8'd3);
    tbl[8]  = mk(0, 0, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 0, 1, 1, 3'd2, 32'h22,       8'd4);
    tbl[9]  = mk(0, 1, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 0, 0, 0, 3'd2, 32'h22,       8'd4);
    tbl[10] = mk(0, 1, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 0, 0, 0, 3'd2, 32'h22,       8'd4);
    tbl[11] = mk(0, 1, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 0, 0, 0, 3'd2, 32'h22,       8'd4);
    tbl[12] = mk(0, 0, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 1, 0, 1, 3'd1, 32'h11,       8'd5);
    tbl[13] = mk(0, 0, 1, 3'd1, 32'h11,       1, 3'd2, 32'h22, 0, 1, 1, 3'd2, 32'h22,       8'd6);
    tbl[14] = mk(0, 0, 1, 3'd5, 32'hA,        1, 3'd5, 32'hB,  1, 0, 1, 3'd5, 32'hA,        8'd7);
    tbl[15] = mk(0, 0, 0, 3'd5, 32'hA,        1, 3'd5, 32'hB,  0, 1, 1, 3'd5, 32'hB,        8'd7);
    tbl[16] = mk(1, 0, 1, 3'd6, 32'h66,       0, 3'd0, 32'h0,  0, 0, 0, 3'd0, 32'h0,        8'd0);
    tbl[17] = mk(0, 0, 0, 3'd0, 32'h0,        0, 3'd0, 32'h0,  0, 0, 0, 3'd0, 32'h0,        8'd0);

    tick();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].hold, tbl[i].v0, tbl[i].a0, tbl[i].d0,
            tbl[i].v1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("v%0d rdy0", i), {31'd0, rdy0_r}, {31'd0, tbl[i].e_rdy0});
      chk($sformatf("v%0d rdy1", i), {31'd0, rdy1_r}, {31'd0, tbl[i].e_rdy1});
      tick();
      chk($sformatf("v%0d we", i), {31'd0, we_r}, {31'd0, tbl[i].e_we});
      chk($sformatf("v%0d wa", i), {29'd0, wa_r}, {29'd0, tbl[i].e_wa});
      chk($sformatf("v%0d wd", i), wd_r, tbl[i].e_wd);
      chk($sformatf("v%0d conflicts", i), {24'd0, cf_r}, {24'd0, tbl[i].e_cf});
    end

    // Fixed priority: req0 wins every conflict, req1 goes once v0 drops.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fp c%0d rdy0", i), {31'd0, rdy0_f}, 32'd1);
      chk($sformatf("fp c%0d rdy1", i), {31'd0, rdy1_f}, 32'd0);
      tick();
      chk($sformatf("fp c%0d wa", i), {29'd0, wa_f}, 32'd1);
    end
    chk("fp conflicts", {24'd0, cf_f}, 32'd4);
    v0 = 1'b0;
    #1;
    chk("fp rdy1 after drop", {31'd0, rdy1_f}, 32'd1);
    tick();
    chk("fp we req1", {31'd0, we_f}, 32'd1);
    chk("fp wa req1", {29'd0, wa_f}, 32'd2);
    chk("fp wd req1", wd_f, 32'h22);

    // Saturation of the conflict counter, and mutual exclusion of grants.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
    for (int i = 1; i <= 260; i++) begin
      #1;
      if (rdy0_r && rdy1_r) chk("rr both rdy", 32'd1, 32'd0);
      tick();
      if (i == 254) chk("conflicts 254", {24'd0, cf_r}, 32'd254);
      if (i == 255) chk("conflicts 255", {24'd0, cf_r}, 32'd255);
    end
    chk("conflicts saturated", {24'd0, cf_r}, 32'd255);
    chk("fp conflicts saturated", {24'd0, cf_f}, 32'd255);

`ifdef RF_WB_FWD_EN
    drive(1'b0, 1'b0, 1'b1, 3'd5, 32'h12345678, 1'b0, 3'd0, 32'h0);
    tick();
    v0 = 1'b0;
    ra1 = 3'd5; rf_rd1 = 32'hAAAA0000;
    ra2 = 3'd4; rf_rd2 = 32'h44444444;
    #1;
    chk("fwd_rd1 bypass", fwd1_r, 32'h12345678);
    chk("fwd_rd2 passthru", fwd2_r, 32'h44444444);
    tick();
    chk("fwd_rd1 after write", fwd1_r, 32'hAAAA0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
